fb_write_scheduler: RTL
=======================

# fb_write_scheduler

Write-side sequencer for the 2-bit × 2048 framebuffer RAM in the LED display path. Accepts pixel bytes over a valid/ready stream and unpacks each byte into four 2-bit RAM writes at consecutive addresses. Also runs a full-RAM clear/fill on request, arbitrating it against the byte stream. Drives the RAM write port directly; the read side is untouched.

## Interface
Parameters:
- `ADDR_W`: default 11; RAM address width (depth 2^ADDR_W).
- `DATA_W`: default 2; RAM word width.
- `BYTE_W`: default 8; input byte width. Must equal `DATA_W` × 4.

Ports:
- `clk`: in, 1; sole clock.
- `reset`: in, 1; synchronous, active-high.
- `byte_valid`: in, 1; input byte present.
- `byte_data`: in, `BYTE_W`; pixel byte.
- `byte_ready`: out, 1; scheduler can accept a byte this cycle.
- `start_load`: in, 1; load the write pointer from `start_addr`.
- `start_addr`: in, `ADDR_W`; new pointer value.
- `clear_req`: in, 1; request a fill of all RAM words.
- `clear_value`: in, `DATA_W`; fill value.
- `clear_busy`: out, 1; fill in progress or pending.
- `ram_waddr`: out, `ADDR_W`; RAM write address.
- `ram_wdata`: out, `DATA_W`; RAM write data.
- `ram_we`: out, 1; RAM write enable.
- `ram_wclke`: out, 1; RAM write clock enable, equal to `ram_we`.
- `frame_done`: out, 1; one-cycle pulse when address 2^ADDR_W−1 is written.

## Operation
- **States:** IDLE, SLICE, CLEAR. Internal registers:
  - `ptr`: `ADDR_W` bits.
  - `slice_cnt`: 2 bits.
  - `byte_reg`, `clr_val_reg`.
  - `clear_pending`.
  - `clr_addr`.
- **byte_ready** is `!reset && !clear_pending && !clear_req` AND (state==IDLE OR (state==SLICE && slice_cnt==3)).
- **Byte handshake** (`byte_valid && byte_ready`):
  - Capture `byte_data`.
  - Go to (or stay in) SLICE with `slice_cnt`=0.
- **SLICE:** emits one write per cycle, MSB first.
  - Order is `[7:6]`, `[5:4]`, `[3:2]`, `[1:0]`.
  - Write address is `ptr`; `ptr` increments after every write.
  - `ptr` wraps modulo 2^ADDR_W, so 2047→0.
  - After `slice_cnt`==3: go to SLICE if a new byte was accepted, otherwise go to IDLE.
- **Clear arbitration:**
  - `clear_req` sampled in IDLE with no byte handshake → CLEAR.
  - `clear_req` during SLICE sets `clear_pending`. The current byte completes, then CLEAR is entered; no new byte is accepted meanwhile.
  - If `clear_req` and `byte_valid` are both high in IDLE, clear wins, because ready is low.
  - `clear_value` is captured when CLEAR is entered.
- **CLEAR:**
  - Writes `clr_val_reg` to addresses 0..2^ADDR_W−1, one per cycle.
  - Then sets `ptr`=0, clears `clear_pending`, and returns to IDLE.
  - `clear_req` during CLEAR is ignored; it does not queue.
- **start_load:** honoured only in IDLE.
  - When honoured, `ptr`←`start_addr`.
  - If a byte handshake happens in the same cycle, the byte's first slice goes to `start_addr`.
  - `start_load` in SLICE or CLEAR is ignored.
- **frame_done:** pulses in the same cycle as `ram_we` for address 2^ADDR_W−1, in both SLICE and CLEAR.
- **clear_busy:** `clear_pending` OR state==CLEAR.

## Timing
- **Reset values:**
  - Registered outputs: `ram_we`=0, `ram_wclke`=0, `ram_waddr`=0, `ram_wdata`=0, `frame_done`=0, `clear_busy`=0.
  - Internal: `ptr`=0, state=IDLE.
  - `byte_ready`=0 while `reset` is high.
- **Reset mid-operation:** aborts the byte or clear immediately. No further writes occur; the partial byte and pending clear are discarded.
- **Write outputs are registered.** A handshake at cycle t gives `ram_we`=1 at t+1..t+4, to addresses p..p+3.
- **Back-to-back bytes:** sustained throughput is 1 byte per 4 cycles, and `ram_we` stays continuously high.
- **Clear from IDLE:**
  - `clear_req` at cycle t → `ram_we` at t+1..t+2^ADDR_W.
  - `clear_busy` is high from t+1 through the cycle of the last write.
  - `byte_ready` returns the cycle after the last write.
- **Pending clear:** the first clear write follows the 4th slice with no gap.
- **RAM write latency:** the RAM captures on the same `clk` edge that samples `ram_we`, so there is no extra latency.

## Structure
- Package `fb_pkg`:
  - `ADDR_W`, `DATA_W`, `SLICES_PER_BYTE`=4.
  - State enum `fb_wr_state_t` {IDLE, SLICE, CLEAR}.
- Single module, no sub-module.
- The pointer/wrap logic is small enough to stay inline.
- The top level instantiates this block alongside the RAM wrapper and connects `clk` to both `ClockA` and the scheduler.

## Test plan
- **Single byte:** reset, then `start_load` with `start_addr`=0x010 plus handshake `byte_data`=0xE4 → writes 3,2,1,0 at 0x010..0x013, `frame_done` never high.
- **Back-to-back bytes:** 0xFF then 0x00 held valid → 8 consecutive `ram_we` cycles, data 3,3,3,3,0,0,0,0, no gap, `byte_ready` high only on cycles 4 and 8.
- **Wrap:** `ptr`=0x7FE plus byte 0x1B → writes 0 @0x7FE, 1 @0x7FF (with `frame_done`=1), 2 @0x000, 3 @0x001.
- **Clear during slice:** `clear_req` with `clear_value`=2 at slice 1 → byte finishes, then 2048 writes of 2 from 0 to 0x7FF, `frame_done` on the last, `ptr`=0, `clear_busy` then drops.
- **Simultaneous requests in IDLE:** `clear_req` and `byte_valid` both high → `byte_ready`=0, clear runs first, byte accepted afterward and written at address 0.
- **Reset mid-clear:** `reset` at clear write #100 → next cycle `ram_we`=0 and `clear_busy`=0; after release, `byte_ready`=1 and `ptr`=0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants and state encoding for the framebuffer write path.
package fb_pkg;

    localparam int ADDR_W          = 11;
    localparam int DATA_W          = 2;
    localparam int SLICES_PER_BYTE = 4;

    typedef enum logic [1:0] {
        IDLE,
        SLICE,
        CLEAR
    } fb_wr_state_t;

endpackage

// File: rtl/fb_write_scheduler.sv
// Unpacks pixel bytes into 2-bit framebuffer writes and runs full-RAM clears,
// driving the RAM write port from registered outputs.
module fb_write_scheduler #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 2,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    input  logic              start_load,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              clear_req,
    input  logic [DATA_W-1:0] clear_value,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_wclke,
    output logic              frame_done
);
    import fb_pkg::*;

    fb_wr_state_t      state, stateNext;
    logic [ADDR_W-1:0] ptr, ptrNext;
    logic [1:0]        sliceCnt, sliceCntNext;
    logic [BYTE_W-1:0] byteReg, byteRegNext;
    logic [DATA_W-1:0] clrValReg, clrValRegNext;
    logic              clearPending, clearPendingNext;
    logic [ADDR_W-1:0] clrAddr, clrAddrNext;

    logic              weNext;
    logic [ADDR_W-1:0] waddrNext;
    logic [DATA_W-1:0] wdataNext;
    logic              lastSlice;
    logic              byteFire;

    // Slice 0 is the most significant DATA_W bits of the byte.
    function automatic logic [DATA_W-1:0] sliceOf(input logic [BYTE_W-1:0] b,
                                                  input logic [1:0]        s);
        logic [BYTE_W-1:0] shifted;
        shifted = b >> ((SLICES_PER_BYTE - 1 - int'(s)) * DATA_W);
        return shifted[DATA_W-1:0];
    endfunction

    assign lastSlice  = (sliceCnt == 2'(SLICES_PER_BYTE - 1));
    assign byte_ready = !reset && !clearPending && !clear_req &&
                        ((state == IDLE) || ((state == SLICE) && lastSlice));
    assign byteFire   = byte_valid && byte_ready;
    assign clear_busy = clearPending || (state == CLEAR);
    assign ram_wclke  = ram_we;

    always_comb begin
        stateNext        = state;
        ptrNext          = ptr;
        sliceCntNext     = sliceCnt;
        byteRegNext      = byteReg;
        clrValRegNext    = clrValReg;
        clearPendingNext = clearPending;
        clrAddrNext      = clrAddr;

        case (state)
            IDLE: begin
                if (start_load) ptrNext = start_addr;
                if (byteFire) begin
                    byteRegNext  = byte_data;
                    sliceCntNext = '0;
                    stateNext    = SLICE;
                end else if (clear_req) begin
                    clrAddrNext   = '0;
                    clrValRegNext = clear_value;
                    stateNext     = CLEAR;
                end
            end
            SLICE: begin
                ptrNext      = ptr + ADDR_W'(1);
                sliceCntNext = sliceCnt + 2'd1;
                if (clear_req) clearPendingNext = 1'b1;
                if (lastSlice) begin
                    if (byteFire) begin
                        byteRegNext  = byte_data;
                        sliceCntNext = '0;
                    end else if (clearPending || clear_req) begin
                        clearPendingNext = 1'b0;
                        clrAddrNext      = '0;
                        clrValRegNext    = clear_value;
                        stateNext        = CLEAR;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            CLEAR: begin
                clrAddrNext = clrAddr + ADDR_W'(1);
                if (clrAddr == {ADDR_W{1'b1}}) begin
                    ptrNext          = '0;
                    clearPendingNext = 1'b0;
                    stateNext        = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase

        // The write port is registered, so it presents the write owned by the next state.
        weNext    = (stateNext != IDLE);
        waddrNext = '0;
        wdataNext = '0;
        if (stateNext == SLICE) begin
            waddrNext = ptrNext;
            wdataNext = sliceOf(byteRegNext, sliceCntNext);
        end else if (stateNext == CLEAR) begin
            waddrNext = clrAddrNext;
            wdataNext = clrValRegNext;
        end
    end

    // Stage p1: control state and RAM write port
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            sliceCnt     <= '0;
            clearPending <= 1'b0;
            clrAddr      <= '0;
            ram_we       <= 1'b0;
            ram_waddr    <= '0;
            ram_wdata    <= '0;
            frame_done   <= 1'b0;
        end else begin
            state        <= stateNext;
            ptr          <= ptrNext;
            sliceCnt     <= sliceCntNext;
            clearPending <= clearPendingNext;
            clrAddr      <= clrAddrNext;
            ram_we       <= weNext;
            ram_waddr    <= waddrNext;
            ram_wdata    <= wdataNext;
            frame_done   <= weNext && (waddrNext == {ADDR_W{1'b1}});
        end
    end

    always_ff @(posedge clk) begin
        byteReg   <= byteRegNext;
        clrValReg <= clrValRegNext;
    end

endmodule
